// File: rtl/fetch_prefetch_pkg.sv
// Shared constants for the instruction prefetch unit: FSM state encodings,
// reset/NOP defaults and PC alignment helper.
package fetch_prefetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the prefetch queue;
// flush empties it in one cycle, pointers wrap modulo DEPTH (power of 2).
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !w_full && !i_flush;
   assign w_do_pop  = i_pop && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // storage is data-only: no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: one outstanding imem request, DEPTH-entry queue,
// redirect flush. Define FETCH_PERF_EN to build the fetch/bubble counters.
module fetch_prefetch
   import fetch_prefetch_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_redirect,
   input  logic [31:0] i_target,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_imem_stb,
   output logic [31:0] o_iaddr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_inst,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_bubble_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [1:0]    r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_iaddr;
   logic [31:0]   w_tgt;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_cnt_next;
   logic [63:0]   w_head;

   assign w_tgt      = align_pc(i_target);
   assign w_push     = (r_state == ST_REQ) && i_imem_ack && !i_redirect;
   assign w_pop      = !w_empty && i_ready && !i_redirect;
   // occupancy after this edge must leave room for the response we are about to request
   assign w_cnt_next = w_count + CW'(w_push) - CW'(w_pop);
   assign w_issue    = (w_cnt_next < CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= PC_RESET;
         r_iaddr    <= '0;
      end else if (i_redirect) begin
         r_fetch_pc <= w_tgt;
         case (r_state)
            ST_IDLE: begin
               r_state    <= ST_REQ;
               r_iaddr    <= w_tgt;
               r_fetch_pc <= w_tgt + 32'd4;
            end
            ST_REQ:  r_state <= i_imem_ack ? ST_IDLE : ST_DROP;
            ST_DROP: if (i_imem_ack) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_issue) begin
                  r_state    <= ST_REQ;
                  r_iaddr    <= r_fetch_pc;
                  r_fetch_pc <= r_fetch_pc + 32'd4;
               end
            end
            ST_REQ: begin
               if (i_imem_ack) begin
                  if (w_issue) begin
                     r_iaddr    <= r_fetch_pc;
                     r_fetch_pc <= r_fetch_pc + 32'd4;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_DROP: if (i_imem_ack) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (i_redirect),
      .i_push  (w_push),
      .i_data  ({r_iaddr, i_inst}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign o_imem_stb = rst_n && ((r_state == ST_REQ) || (r_state == ST_DROP));
   assign o_iaddr    = rst_n ? r_iaddr : 32'd0;
   assign o_valid    = !w_empty;
   assign o_pc       = w_empty ? 32'd0 : w_head[63:32];
   assign o_instr    = w_empty ? NOP_INSTR : w_head[31:0];

`ifdef FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (w_pop)              r_fetch_cnt  <= r_fetch_cnt + 32'd1;
         if (i_ready && w_empty) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign o_fetch_cnt  = r_fetch_cnt;
   assign o_bubble_cnt = r_bubble_cnt;
`else
   assign o_fetch_cnt  = 32'd0;
   assign o_bubble_cnt = 32'd0;
`endif

endmodule
